cache_fill_arbiter: RTL and testbench
=====================================

// Module: cache_fill_arbiter
// PURPOSE
//   Shares the single multi-cycle main memory between the I-cache and D-cache miss paths.
//   Grants one requester at a time. For a fill, issues WORDS_PER_BLK sequential word reads and
//   steers the returning words to the granted cache. Also sequences single-word D-cache
//   write-through stores. Sits between both cache controllers and the main memory.
// PARAMETERS
//   ADDR_W        16  byte-address width
//   DATA_W        16  word width
//   WORDS_PER_BLK 8   words per cache block (power of 2); block = WORDS_PER_BLK*2 bytes
// PORTS
//   clk           in   1       clock; all state updates on posedge
//   rst           in   1       asynchronous, active-high reset
//   ic_miss_req   in   1       I-cache fill request; level, held until ic_fill_done
//   ic_miss_addr  in   ADDR_W  I-cache miss byte address; stable while ic_miss_req is high
//   dc_miss_req   in   1       D-cache fill request; level, held until dc_fill_done
//   dc_miss_addr  in   ADDR_W  D-cache miss byte address; stable while dc_miss_req is high
//   dc_wr_req     in   1       D-cache write-through request; held until dc_wr_ack
//   dc_wr_addr    in   ADDR_W  store byte address
//   dc_wr_data    in   DATA_W  store data
//   mem_en        out  1       memory access this cycle
//   mem_wr        out  1       1 = write, 0 = read (valid when mem_en=1)
//   mem_addr      out  ADDR_W  memory byte address
//   mem_wdata     out  DATA_W  memory write data
//   mem_rvalid    in   1       read data valid from memory (fixed latency, in order)
//   mem_rdata     in   DATA_W  read data
//   fill_data     out  DATA_W  returned word (= mem_rdata)
//   fill_idx      out  log2(WORDS_PER_BLK)  word index within block of fill_data
//   ic_fill_we    out  1       write fill_data into I-cache data array
//   dc_fill_we    out  1       write fill_data into D-cache data array
//   ic_fill_done  out  1       one-cycle pulse: last I-cache word delivered
//   dc_fill_done  out  1       one-cycle pulse: last D-cache word delivered
//   dc_wr_ack     out  1       one-cycle pulse: store issued to memory
//   busy          out  1       state != IDLE
// BEHAVIOUR
//   Reset: state=IDLE, counters=0, grant regs=0. All outputs 0 (mem_addr/mem_wdata 0).
//   States: IDLE -> {WRITE | FILL}. WRITE -> IDLE after 1 cycle. FILL -> IDLE when rx_cnt completes.
//   IDLE arbitration (registered; grant takes effect the next cycle):
//     dc_wr_req > dc_miss_req > ic_miss_req (fixed priority, default build).
//   WRITE: mem_en=1, mem_wr=1, mem_addr=dc_wr_addr, mem_wdata=dc_wr_data, dc_wr_ack=1, then IDLE.
//   FILL:
//     Latch blk = miss_addr with low log2(WORDS_PER_BLK)+1 bits cleared.
//     Issue: tx_cnt runs 0..N-1, one read per cycle for N consecutive cycles starting with the
//       first FILL cycle. mem_en=1, mem_wr=0, mem_addr = blk | (tx_cnt<<1). No issue after N reads.
//     Return: each mem_rvalid -> fill_data=mem_rdata, fill_idx=rx_cnt, granted *_fill_we=1,
//       rx_cnt++. On the valid with rx_cnt==N-1: *_fill_done=1 in the same cycle; next state IDLE.
//     Fill occupancy = N + memory latency cycles. The arbiter never counts latency.
//   Back-to-back: a new grant is made in the IDLE cycle after DONE. Minimum 1 idle cycle between
//     operations.
//   mem_rvalid while in IDLE or WRITE: ignored; no *_fill_we.
//   Requester drops its request mid-fill: the fill runs to completion with fill_we/done asserted.
//   Simultaneous ic and dc miss in IDLE: dc wins; ic waits, is not lost, and is granted after.
//   Store arriving during a fill: waits, and is granted before any pending fill.
//   rst asserted mid-operation: immediate return to reset state; in-flight memory reads are
//     discarded (memory shares rst).
// CONFIGURATION
//   ARB_ROUND_ROBIN_EN defined: I-cache vs D-cache fill priority alternates. The last-granted
//     fill requester loses a tie, tracked by a 1-bit last_fill_dc reg (reset 0 -> dc first).
//     dc_wr_req stays highest priority.
//   Not defined: fixed dc > ic fill priority; last_fill_dc is not built.
// STRUCTURE
//   Package cache_mem_pkg: arb_state_t enum {IDLE, WRITE, FILL}; GRANT_IC/GRANT_DC constants;
//     WORDS_PER_BLK default; OFF_W = log2(WORDS_PER_BLK).
//   Sub-module blk_word_counter: OFF_W-bit counter with clr, inc and last outputs.
//     Instanced twice: tx_cnt and rx_cnt.
// TESTING (memory model: 4-cycle read latency, pipelined)
//   1. ic_miss_req, addr 0x1236 -> reads 0x1230,0x1232..0x123E on 8 consecutive cycles;
//      8 ic_fill_we with idx 0..7; ic_fill_done on idx 7; busy for 12 cycles.
//   2. ic and dc miss same cycle (dc 0x4000, ic 0x0010) -> dc fill completes first, then ic fill;
//      with ARB_ROUND_ROBIN_EN and a preceding dc fill -> ic first.
//   3. dc_wr_req 0x2002/0xBEEF raised during an ic fill, plus a pending dc miss -> store issued
//      (mem_wr=1, 0xBEEF) and acked before the dc fill starts.
//   4. mem_rvalid pulses in IDLE -> no fill_we, no state change.
//   5. rst pulse after 3 fill words -> all outputs 0 at once; the next request restarts at idx 0;
//      stale data is not delivered.
//   6. ic_miss_req dropped after 2 cycles -> fill still delivers 8 words and ic_fill_done.

Source files
------------

// File: rtl/cache_mem_pkg.sv
// Shared types and constants for the cache fill arbiter.
package cache_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FILL  = 2'd2
    } arb_state_t;

    localparam logic GRANT_IC = 1'b0;
    localparam logic GRANT_DC = 1'b1;

    localparam int DEF_WORDS_PER_BLK = 8;
    localparam int OFF_W             = $clog2(DEF_WORDS_PER_BLK);

endpackage

// File: rtl/blk_word_counter.sv
// Word-within-block counter: synchronous clear, increment, and a last-word flag.
// Latency: count updates on the clock edge after clr/inc. Backpressure: none, driven by the owner FSM.
module blk_word_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         last
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign last = &cnt;

endmodule

// File: rtl/cache_fill_arbiter.sv
// Shares one main-memory port between I/D-cache block fills and D-cache write-through stores.
// Latency: grant 1 cycle after request; a fill lasts WORDS_PER_BLK issue cycles plus memory latency.
// Backpressure: requests are level-held until done/ack; ARB_ROUND_ROBIN_EN alternates fill priority.
module cache_fill_arbiter
    import cache_mem_pkg::*;
#(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 16,
    parameter int WORDS_PER_BLK = DEF_WORDS_PER_BLK
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ic_miss_req,
    input  logic [ADDR_W-1:0]                ic_miss_addr,
    input  logic                             dc_miss_req,
    input  logic [ADDR_W-1:0]                dc_miss_addr,
    input  logic                             dc_wr_req,
    input  logic [ADDR_W-1:0]                dc_wr_addr,
    input  logic [DATA_W-1:0]                dc_wr_data,
    output logic                             mem_en,
    output logic                             mem_wr,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [DATA_W-1:0]                mem_wdata,
    input  logic                             mem_rvalid,
    input  logic [DATA_W-1:0]                mem_rdata,
    output logic [DATA_W-1:0]                fill_data,
    output logic [$clog2(WORDS_PER_BLK)-1:0] fill_idx,
    output logic                             ic_fill_we,
    output logic                             dc_fill_we,
    output logic                             ic_fill_done,
    output logic                             dc_fill_done,
    output logic                             dc_wr_ack,
    output logic                             busy
);

    localparam int OW = $clog2(WORDS_PER_BLK);
    localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'((1 << (OW + 1)) - 1);

    arb_state_t        state;
    logic              grant;
    logic              issuing;
    logic [ADDR_W-1:0] blk;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [OW-1:0]     tx_cnt;
    logic [OW-1:0]     rx_cnt;
    logic              tx_last;
    logic              rx_last;
    logic              start_fill;
    logic              pick_dc;
    logic              rx_fire;

`ifdef ARB_ROUND_ROBIN_EN
    // The fill requester granted last loses a simultaneous tie.
    logic last_fill_dc;

    assign pick_dc = dc_miss_req && (!ic_miss_req || !last_fill_dc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_fill_dc <= 1'b0;
        end else if (start_fill) begin
            last_fill_dc <= pick_dc;
        end
    end
`else
    assign pick_dc = dc_miss_req;
`endif

    assign start_fill = (state == IDLE) && !dc_wr_req && (dc_miss_req || ic_miss_req);
    assign rx_fire    = (state == FILL) && mem_rvalid;

    blk_word_counter #(.W(OW)) u_tx_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_fill),
        .inc  ((state == FILL) && issuing && !tx_last),
        .cnt  (tx_cnt),
        .last (tx_last)
    );

    blk_word_counter #(.W(OW)) u_rx_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_fill),
        .inc  (rx_fire),
        .cnt  (rx_cnt),
        .last (rx_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            grant   <= GRANT_IC;
            issuing <= 1'b0;
            blk     <= '0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dc_wr_req) begin
                        state   <= WRITE;
                        wr_addr <= dc_wr_addr;
                        wr_data <= dc_wr_data;
                    end else if (start_fill) begin
                        state   <= FILL;
                        grant   <= pick_dc ? GRANT_DC : GRANT_IC;
                        blk     <= (pick_dc ? dc_miss_addr : ic_miss_addr) & BLK_MASK;
                        issuing <= 1'b1;
                    end
                end
                WRITE: state <= IDLE;
                FILL: begin
                    // Issue stops after N reads; returns are counted independently of latency.
                    if (issuing && tx_last) begin
                        issuing <= 1'b0;
                    end
                    if (rx_fire && rx_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        dc_wr_ack    = 1'b0;
        if (state == WRITE) begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
            dc_wr_ack = 1'b1;
        end else if ((state == FILL) && issuing) begin
            mem_en   = 1'b1;
            mem_addr = blk | (ADDR_W'(tx_cnt) << 1);
        end
    end

    assign fill_data    = rx_fire ? mem_rdata : '0;
    assign fill_idx     = rx_cnt;
    assign ic_fill_we   = rx_fire && (grant == GRANT_IC);
    assign dc_fill_we   = rx_fire && (grant == GRANT_DC);
    assign ic_fill_done = ic_fill_we && rx_last;
    assign dc_fill_done = dc_fill_we && rx_last;
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Bench for cache_fill_arbiter: 4-cycle pipelined memory, directed scenarios and randomized rounds.
module tb_cache_fill_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ic_miss_req, dc_miss_req, dc_wr_req;
    logic [15:0] ic_miss_addr, dc_miss_addr, dc_wr_addr, dc_wr_data;
    logic        mem_en, mem_wr, mem_rvalid;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data;
    logic [2:0]  fill_idx;
    logic        ic_fill_we, dc_fill_we, ic_fill_done, dc_fill_done, dc_wr_ack, busy;

    always #5 clk = ~clk;

    cache_fill_arbiter dut (
        .clk(clk), .rst(rst),
        .ic_miss_req(ic_miss_req), .ic_miss_addr(ic_miss_addr),
        .dc_miss_req(dc_miss_req), .dc_miss_addr(dc_miss_addr),
        .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr), .dc_wr_data(dc_wr_data),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .fill_data(fill_data), .fill_idx(fill_idx),
        .ic_fill_we(ic_fill_we), .dc_fill_we(dc_fill_we),
        .ic_fill_done(ic_fill_done), .dc_fill_done(dc_fill_done),
        .dc_wr_ack(dc_wr_ack), .busy(busy)
    );

    // Memory contents are a fixed function of the word address.
    function automatic logic [15:0] memfn(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    // Pipelined read memory, 4-cycle latency, flushed by rst.
    logic [3:0]  pv;
    logic [15:0] pa [4];
    logic        inj_v;
    logic [15:0] inj_d;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pv <= 4'b0;
        end else begin
            pv    <= {pv[2:0], mem_en && !mem_wr};
            pa[0] <= mem_addr;
            pa[1] <= pa[0];
            pa[2] <= pa[1];
            pa[3] <= pa[2];
        end
    end
    assign mem_rvalid = pv[3] | inj_v;
    assign mem_rdata  = pv[3] ? memfn(pa[3]) : inj_d;

    typedef struct {
        logic        is_wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          busy_len, nrd, ndl, nack;
        logic [15:0] rd_addr [8];
        int          rd_at [8];
        logic [2:0]  dl_idx [8];
        logic [15:0] dl_data [8];
        logic [3:0]  dl_flags [8];   // {ic_we, dc_we, ic_done, dc_done}
    } op_t;

    typedef struct {
        bit          is_wr;
        bit          dc;
        logic [15:0] addr;
        logic [15:0] wdata;
    } eop_t;

    op_t  obs_ops[$];
    op_t  cur;
    bit   prev_busy;
    int   stray;
    bit   model_last_dc;
    int   checks = 0;
    int   errors = 0;

    function automatic bit ref_tie_dc();
`ifdef ARB_ROUND_ROBIN_EN
        return !model_last_dc;
`else
        return 1'b1;
`endif
    endfunction

    // One clock: sample at negedge, log the transaction, let requesters drop on done/ack.
    task automatic step();
        @(negedge clk);
        if (busy) begin
            if (!prev_busy) begin
                cur.is_wr = mem_wr; cur.addr = mem_addr; cur.wdata = mem_wdata;
                cur.busy_len = 0; cur.nrd = 0; cur.ndl = 0; cur.nack = 0;
            end
            if (mem_en && !mem_wr) begin
                if (cur.nrd < 8) begin
                    cur.rd_addr[cur.nrd] = mem_addr;
                    cur.rd_at[cur.nrd]   = cur.busy_len;
                end
                cur.nrd++;
            end
            if (ic_fill_we || dc_fill_we) begin
                if (cur.ndl < 8) begin
                    cur.dl_idx[cur.ndl]   = fill_idx;
                    cur.dl_data[cur.ndl]  = fill_data;
                    cur.dl_flags[cur.ndl] = {ic_fill_we, dc_fill_we, ic_fill_done, dc_fill_done};
                end
                cur.ndl++;
            end
            if (dc_wr_ack) cur.nack++;
            cur.busy_len++;
        end else begin
            if (prev_busy) obs_ops.push_back(cur);
            if (ic_fill_we || dc_fill_we || ic_fill_done || dc_fill_done || mem_en || dc_wr_ack) stray++;
        end
        prev_busy = busy;
        if (ic_fill_done) ic_miss_req = 1'b0;
        if (dc_fill_done) dc_miss_req = 1'b0;
        if (dc_wr_ack)    dc_wr_req   = 1'b0;
    endtask

    task automatic run_until_ops(input int n);
        for (int i = 0; i < 200 && obs_ops.size() < n; i++) step();
        checks++;
        if (obs_ops.size() != n) begin
            errors++;
            $display("FAIL op_count got %0d want %0d", obs_ops.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ic_miss_req = 0; dc_miss_req = 0; dc_wr_req = 0; inj_v = 0; inj_d = 0;
        ic_miss_addr = 0; dc_miss_addr = 0; dc_wr_addr = 0; dc_wr_data = 0;
        prev_busy = 0; stray = 0; model_last_dc = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_idx, ic_fill_we, dc_fill_we,
             ic_fill_done, dc_fill_done, dc_wr_ack, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs en=%b addr=%h busy=%b idx=%0d want all zero", mem_en, mem_addr, busy, fill_idx);
        end
        rst = 1'b0;
        repeat (3) step();
        checks++;
        if (busy !== 1'b0 || stray != 0) begin
            errors++;
            $display("FAIL reset_idle busy=%b stray=%0d want 0/0", busy, stray);
        end
    endtask

    task automatic test_fill_basic();
        obs_ops.delete();
        ic_miss_addr = 16'h1236; ic_miss_req = 1'b1;
        model_last_dc = 0;
        run_until_ops(1);
        if (obs_ops.size() == 1) begin
            checks++;
            if (obs_ops[0].nrd != 8 || obs_ops[0].ndl != 8 || obs_ops[0].busy_len != 12) begin
                errors++;
                $display("FAIL basic_counts reads=%0d words=%0d busy=%0d want 8/8/12",
                         obs_ops[0].nrd, obs_ops[0].ndl, obs_ops[0].busy_len);
            end
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (obs_ops[0].rd_addr[k] !== 16'h1230 + 16'(2 * k) || obs_ops[0].rd_at[k] != k) begin
                    errors++;
                    $display("FAIL basic_read%0d addr=%h cyc=%0d want %h/%0d", k, obs_ops[0].rd_addr[k],
                             obs_ops[0].rd_at[k], 16'h1230 + 16'(2 * k), k);
                end
                checks++;
                if ({obs_ops[0].dl_idx[k], obs_ops[0].dl_data[k], obs_ops[0].dl_flags[k]} !==
                    {3'(k), memfn(16'h1230 + 16'(2 * k)), 1'b1, 1'b0, (k == 7), 1'b0}) begin
                    errors++;
                    $display("FAIL basic_word%0d idx=%0d data=%h flags=%b want %0d/%h/10%b0", k,
                             obs_ops[0].dl_idx[k], obs_ops[0].dl_data[k], obs_ops[0].dl_flags[k],
                             k, memfn(16'h1230 + 16'(2 * k)), (k == 7));
                end
            end
        end
    endtask

    task automatic test_simultaneous_miss();
        bit first_dc;
        obs_ops.delete();
        dc_miss_addr = 16'h6008; dc_miss_req = 1'b1;
        run_until_ops(1);
        model_last_dc = 1;
        step();
        first_dc = ref_tie_dc();
        dc_miss_addr = 16'h4000; ic_miss_addr = 16'h0010;
        dc_miss_req = 1'b1; ic_miss_req = 1'b1;
        run_until_ops(3);
        model_last_dc = !first_dc;
        if (obs_ops.size() == 3) begin
            checks++;
            if (obs_ops[1].addr !== (first_dc ? 16'h4000 : 16'h0010) ||
                obs_ops[1].dl_flags[7] !== (first_dc ? 4'b0101 : 4'b1010)) begin
                errors++;
                $display("FAIL tie_first addr=%h flags=%b want dc_first=%0b", obs_ops[1].addr,
                         obs_ops[1].dl_flags[7], first_dc);
            end
            checks++;
            if (obs_ops[2].addr !== (first_dc ? 16'h0010 : 16'h4000) || obs_ops[2].ndl != 8) begin
                errors++;
                $display("FAIL tie_second addr=%h words=%0d want dc_first=%0b and 8 words",
                         obs_ops[2].addr, obs_ops[2].ndl, first_dc);
            end
        end
    endtask

    task automatic test_store_priority();
        obs_ops.delete();
        ic_miss_addr = 16'h0104; ic_miss_req = 1'b1;
        repeat (4) step();
        dc_wr_addr = 16'h2002; dc_wr_data = 16'hBEEF; dc_wr_req = 1'b1;
        dc_miss_addr = 16'h0200; dc_miss_req = 1'b1;
        run_until_ops(3);
        model_last_dc = 1;
        if (obs_ops.size() == 3) begin
            checks++;
            if ({obs_ops[1].is_wr, obs_ops[1].addr, obs_ops[1].wdata} !== {1'b1, 16'h2002, 16'hBEEF} ||
                obs_ops[1].nack != 1 || obs_ops[1].busy_len != 1) begin
                errors++;
                $display("FAIL store_op wr=%b addr=%h data=%h acks=%0d len=%0d want 1/2002/beef/1/1",
                         obs_ops[1].is_wr, obs_ops[1].addr, obs_ops[1].wdata, obs_ops[1].nack, obs_ops[1].busy_len);
            end
            checks++;
            if (obs_ops[2].is_wr !== 1'b0 || obs_ops[2].addr !== 16'h0200 || obs_ops[2].dl_flags[7] !== 4'b0101) begin
                errors++;
                $display("FAIL store_then_dc addr=%h flags=%b want 0200/0101", obs_ops[2].addr, obs_ops[2].dl_flags[7]);
            end
        end
    endtask

    task automatic test_rvalid_idle();
        int s0, busy_seen;
        obs_ops.delete();
        s0 = stray; busy_seen = 0;
        for (int i = 0; i < 4; i++) begin
            inj_v = 1'b1; inj_d = 16'($urandom);
            step();
            busy_seen += int'(busy);
            inj_v = 1'b0;
            step();
            busy_seen += int'(busy);
        end
        checks++;
        if (stray != s0 || busy_seen != 0 || obs_ops.size() != 0) begin
            errors++;
            $display("FAIL idle_rvalid stray=%0d busy_cycles=%0d ops=%0d want 0/0/0", stray - s0, busy_seen, obs_ops.size());
        end
    endtask

    task automatic test_reset_mid_fill();
        obs_ops.delete();
        ic_miss_addr = 16'h3000; ic_miss_req = 1'b1;
        for (int i = 0; i < 60 && !(busy && cur.ndl >= 3); i++) step();
        checks++;
        if (cur.ndl != 3) begin
            errors++;
            $display("FAIL midrst_words got %0d want 3", cur.ndl);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_en, mem_addr, fill_data, fill_idx, ic_fill_we, dc_fill_we, ic_fill_done, busy} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs en=%b addr=%h idx=%0d we=%b busy=%b want all zero",
                     mem_en, mem_addr, fill_idx, ic_fill_we, busy);
        end
        ic_miss_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        prev_busy = 0; obs_ops.delete(); model_last_dc = 0;
        dc_miss_addr = 16'h5004; dc_miss_req = 1'b1;
        run_until_ops(1);
        model_last_dc = 1;
        if (obs_ops.size() == 1) begin
            checks++;
            if (obs_ops[0].ndl != 8 || obs_ops[0].dl_idx[0] !== 3'd0 || obs_ops[0].dl_data[0] !== memfn(16'h5000) ||
                obs_ops[0].dl_flags[0] !== 4'b0100 || obs_ops[0].dl_flags[7] !== 4'b0101) begin
                errors++;
                $display("FAIL postrst_fill words=%0d idx0=%0d data0=%h flags0=%b want 8/0/%h/0100",
                         obs_ops[0].ndl, obs_ops[0].dl_idx[0], obs_ops[0].dl_data[0], obs_ops[0].dl_flags[0], memfn(16'h5000));
            end
        end
    endtask

    task automatic test_drop_request();
        obs_ops.delete();
        ic_miss_addr = 16'h004A; ic_miss_req = 1'b1;
        repeat (2) step();
        ic_miss_req = 1'b0;
        run_until_ops(1);
        model_last_dc = 0;
        if (obs_ops.size() == 1) begin
            checks++;
            if (obs_ops[0].ndl != 8 || obs_ops[0].dl_idx[7] !== 3'd7 || obs_ops[0].dl_flags[7] !== 4'b1010 ||
                obs_ops[0].dl_data[7] !== memfn(16'h004E)) begin
                errors++;
                $display("FAIL drop_fill words=%0d idx7=%0d flags7=%b data7=%h want 8/7/1010/%h",
                         obs_ops[0].ndl, obs_ops[0].dl_idx[7], obs_ops[0].dl_flags[7], obs_ops[0].dl_data[7], memfn(16'h004E));
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 24; r++) begin
            eop_t  exp[$];
            eop_t  fills[$];
            eop_t  e;
            op_t   op;
            bit    ri, rd, rw0, rwl, fd;
            int    dl;
            logic [15:0] blk;
            ri = 1'($urandom); rd = 1'($urandom); rw0 = 1'($urandom);
            if (!ri && !rd) rw0 = 1'b1;
            rwl = !rw0 && (ri || rd) && 1'($urandom);
            dl  = $urandom_range(2, 8);
            ic_miss_addr = 16'($urandom); dc_miss_addr = 16'($urandom);
            dc_wr_addr = 16'($urandom); dc_wr_data = 16'($urandom);
            if (ri && rd) begin
                fd = ref_tie_dc();
                fills.push_back('{0, fd, fd ? dc_miss_addr : ic_miss_addr, 0});
                fills.push_back('{0, !fd, fd ? ic_miss_addr : dc_miss_addr, 0});
            end else if (ri || rd) begin
                fills.push_back('{0, rd, rd ? dc_miss_addr : ic_miss_addr, 0});
            end
            foreach (fills[j]) model_last_dc = fills[j].dc;
            if (rw0) exp.push_back('{1, 1, dc_wr_addr, dc_wr_data});
            foreach (fills[j]) begin
                exp.push_back(fills[j]);
                if (rwl && j == 0) exp.push_back('{1, 1, dc_wr_addr, dc_wr_data});
            end
            obs_ops.delete();
            ic_miss_req = ri; dc_miss_req = rd; dc_wr_req = rw0;
            for (int i = 0; i < 200; i++) begin
                if (rwl && i == dl) dc_wr_req = 1'b1;
                step();
                if (i > dl && obs_ops.size() >= exp.size() && !(ic_miss_req || dc_miss_req || dc_wr_req)) break;
            end
            checks++;
            if (obs_ops.size() != exp.size()) begin
                errors++;
                $display("FAIL rand%0d_ops got %0d want %0d", r, obs_ops.size(), exp.size());
            end
            for (int k = 0; k < exp.size() && k < obs_ops.size(); k++) begin
                e = exp[k]; op = obs_ops[k];
                checks++;
                if (op.is_wr !== e.is_wr) begin
                    errors++;
                    $display("FAIL rand%0d_kind op%0d wr=%b want %b", r, k, op.is_wr, e.is_wr);
                end else if (e.is_wr) begin
                    checks++;
                    if (op.addr !== e.addr || op.wdata !== e.wdata || op.nack != 1 || op.busy_len != 1) begin
                        errors++;
                        $display("FAIL rand%0d_store addr=%h data=%h acks=%0d want %h/%h/1", r, op.addr, op.wdata, op.nack, e.addr, e.wdata);
                    end
                end else begin
                    blk = e.addr - (e.addr % 16);
                    checks++;
                    if (op.nrd != 8 || op.ndl != 8 || op.busy_len != 12 || op.nack != 0) begin
                        errors++;
                        $display("FAIL rand%0d_fill_counts reads=%0d words=%0d busy=%0d want 8/8/12", r, op.nrd, op.ndl, op.busy_len);
                    end
                    for (int j = 0; j < 8; j++) begin
                        checks++;
                        if (op.rd_addr[j] !== blk + 16'(2 * j) || op.rd_at[j] != j ||
                            {op.dl_idx[j], op.dl_data[j], op.dl_flags[j]} !==
                            {3'(j), memfn(blk + 16'(2 * j)), !e.dc, e.dc, !e.dc && j == 7, e.dc && j == 7}) begin
                            errors++;
                            $display("FAIL rand%0d_word%0d rd=%h idx=%0d data=%h flags=%b want %h/%0d/%h dc=%0b",
                                     r, j, op.rd_addr[j], op.dl_idx[j], op.dl_data[j], op.dl_flags[j],
                                     blk + 16'(2 * j), j, memfn(blk + 16'(2 * j)), e.dc);
                        end
                    end
                end
            end
            ic_miss_req = 0; dc_miss_req = 0; dc_wr_req = 0;
            repeat (2) step();
        end
    endtask

    initial begin
        test_reset();
        test_fill_basic();
        test_simultaneous_miss();
        test_store_priority();
        test_rvalid_idle();
        test_reset_mid_fill();
        test_drop_request();
        test_random();
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL idle_activity got %0d cycles want 0", stray);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
